// File: rtl/nn_collector_pkg.sv
// Shared types for the NN output collector: pairing FSM states and the aligned
// column-pair word layout.
package nn_collector_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;

    typedef struct packed {
        logic signed [DATA_W_DEFAULT-1:0] col2;
        logic signed [DATA_W_DEFAULT-1:0] col1;
    } pair_t;

    typedef enum logic {
        IDLE,
        HALF
    } pair_state_t;

endpackage

// File: rtl/nn_output_collector_fifo.sv
// collector_fifo: generic first-word-fall-through FIFO; head is driven straight
// from registered storage and reads as zero while empty.
module collector_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W-1:0]             head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign level   = count;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/nn_output_collector.sv
// Re-aligns skewed column-1/column-2 activations into {col2,col1} words and
// queues them for the host. Optional counters: define NN_COLLECTOR_STATS_EN.
module nn_output_collector
    import nn_collector_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        col_data_1,
    input  logic                     col_valid_1,
    input  logic [DATA_W-1:0]        col_data_2,
    input  logic                     col_valid_2,
    input  logic                     flush,
    output logic [2*DATA_W-1:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
`ifdef NN_COLLECTOR_STATS_EN
    output logic [15:0]              drop_count,
    output logic [15:0]              pair_count,
`endif
    output logic                     orphan
);

    pair_state_t         state;
    pair_state_t         state_next;
    logic [DATA_W-1:0]   hold1;
    logic                push;
    logic [2*DATA_W-1:0] push_word;
    logic                orphan_set;
    logic                hold_load;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;

    always_ff @(posedge clk) begin
        if (!rst || flush)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (col_valid_1 && !col_valid_2) state_next = HALF;
            HALF:    if (col_valid_2 && !col_valid_1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        push_word  = '0;
        orphan_set = 1'b0;
        hold_load  = 1'b0;
        case (state)
            IDLE: begin
                if (col_valid_1 && col_valid_2) begin
                    push      = 1'b1;
                    push_word = {col_data_2, col_data_1};
                end else if (col_valid_1) begin
                    hold_load = 1'b1;
                end else if (col_valid_2) begin
                    push       = 1'b1;
                    push_word  = {col_data_2, {DATA_W{1'b0}}};
                    orphan_set = 1'b1;
                end
            end
            HALF: begin
                hold_load = col_valid_1;
                if (col_valid_2) begin
                    push      = 1'b1;
                    push_word = {col_data_2, hold1};
                end else if (col_valid_1) begin
                    // New column-1 sample while the held one is still unpaired.
                    push       = 1'b1;
                    push_word  = {{DATA_W{1'b0}}, hold1};
                    orphan_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || flush)
            hold1 <= '0;
        else if (hold_load)
            hold1 <= col_data_1;
    end

    collector_fifo #(
        .DEPTH (DEPTH),
        .W     (2*DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_word),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level),
        .head      (out_data)
    );

    assign out_valid = !fifo_empty;
    assign drop      = push && fifo_full && !out_ready;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            overflow <= 1'b0;
            orphan   <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            if (orphan_set)
                orphan <= 1'b1;
        end
    end

`ifdef NN_COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            drop_count <= '0;
            pair_count <= '0;
        end else begin
            if (drop && drop_count != '1)
                drop_count <= drop_count + 1'b1;
            if (push && !drop)
                pair_count <= pair_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_output_collector.sv
// Directed self-checking bench for nn_output_collector (DEPTH=8, DATA_W=16);
// counter checks enabled when NN_COLLECTOR_STATS_EN is defined.
module tb_nn_output_collector;
    import nn_collector_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] col_data_1, col_data_2;
    logic        col_valid_1, col_valid_2;
    logic        flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        overflow;
    logic        orphan;
`ifdef NN_COLLECTOR_STATS_EN
    logic [15:0] drop_count, pair_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nn_output_collector #(.DEPTH(8), .DATA_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .col_data_1  (col_data_1),
        .col_valid_1 (col_valid_1),
        .col_data_2  (col_data_2),
        .col_valid_2 (col_valid_2),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
`ifdef NN_COLLECTOR_STATS_EN
        .drop_count  (drop_count),
        .pair_count  (pair_count),
`endif
        .orphan      (orphan)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [15:0] d1, input logic v2, input logic [15:0] d2);
        col_valid_1 = v1;
        col_data_1  = d1;
        col_valid_2 = v2;
        col_data_2  = d2;
    endtask

    function automatic logic [31:0] mk(input logic [15:0] c2, input logic [15:0] c1);
        pair_t p;
        p.col2 = c2;
        p.col1 = c1;
        return p;
    endfunction

    task automatic check_zero(input string tag);
        check_val({tag, "_data"},  out_data, 32'h0);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_level"}, {28'd0, level}, 32'd0);
        check_val({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
        check_val({tag, "_orph"},  {31'd0, orphan}, 32'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic fill_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 1'b1, 16'h0200 + 16'(i));
            step();
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic mid_op_clear(input bit use_flush);
        do_flush();
        out_ready = 1'b0;
        fill_pairs(3);
        drive(1'b1, 16'h0033, 1'b0, 16'h0);
        step();
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_val("midop_level3", {28'd0, level}, 32'd3);
        if (use_flush) begin
            do_flush();
        end else begin
            rst = 1'b0;
            step();
            rst = 1'b1;
        end
        check_zero(use_flush ? "mid_flush" : "mid_rst");
        drive(1'b0, 16'h0, 1'b1, 16'h0077);
        step();
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_val("mid_v2_word",   out_data, 32'h0077_0000);
        check_val("mid_v2_orphan", {31'd0, orphan}, 32'd1);
        check_val("mid_v2_level",  {28'd0, level}, 32'd1);
    endtask

    initial begin
        logic [31:0] got_words [4];
        int          n_got;
        int          max_lvl;

        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        step();
        step();
        rst = 1'b1;
        check_zero("reset");

        // Skewed pair
        drive(1'b1, 16'h0180, 1'b0, 16'h0);
        step();
        check_val("skew_not_yet", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 16'h0, 1'b1, 16'hFF40);
        step();
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_val("skew_word",   out_data, 32'hFF40_0180);
        check_val("skew_valid",  {31'd0, out_valid}, 32'd1);
        check_val("skew_level",  {28'd0, level}, 32'd1);
        check_val("skew_orphan", {31'd0, orphan}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("skew_popped", {28'd0, level}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("empty_pop_ignored", {28'd0, level}, 32'd0);

        // Streaming with skew, host always ready
        out_ready = 1'b1;
        n_got = 0;
        max_lvl = 0;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: drive(1'b1, 16'd1, 1'b0, 16'd0);
                1: drive(1'b1, 16'd2, 1'b1, 16'd11);
                2: drive(1'b1, 16'd3, 1'b1, 16'd12);
                3: drive(1'b1, 16'd4, 1'b1, 16'd13);
                4: drive(1'b0, 16'd0, 1'b1, 16'd14);
                default: drive(1'b0, 16'd0, 1'b0, 16'd0);
            endcase
            step();
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (out_valid && n_got < 4) begin
                got_words[n_got] = out_data;
                n_got++;
            end
        end
        out_ready = 1'b0;
        check_val("stream_count", n_got, 32'd4);
        check_val("stream_w0", got_words[0], mk(16'd11, 16'd1));
        check_val("stream_w1", got_words[1], mk(16'd12, 16'd2));
        check_val("stream_w2", got_words[2], mk(16'd13, 16'd3));
        check_val("stream_w3", got_words[3], mk(16'd14, 16'd4));
        check_val("stream_ovf", {31'd0, overflow}, 32'd0);
        check_val("stream_maxlvl_le2", {31'd0, (max_lvl <= 2)}, 32'd1);

        // Orphan sequence
        drive(1'b1, 16'd5, 1'b0, 16'd0);
        step();
        drive(1'b1, 16'd6, 1'b0, 16'd0);
        step();
        drive(1'b0, 16'd0, 1'b1, 16'd7);
        step();
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_val("orph_flag",  {31'd0, orphan}, 32'd1);
        check_val("orph_level", {28'd0, level}, 32'd2);
        check_val("orph_w0", out_data, 32'h0000_0005);
        out_ready = 1'b1;
        step();
        check_val("orph_w1", out_data, 32'h0007_0006);
        step();
        out_ready = 1'b0;
        check_val("orph_empty", {31'd0, out_valid}, 32'd0);
        do_flush();
        check_val("flush_orph_clr", {31'd0, orphan}, 32'd0);

        // Fill past capacity
        fill_pairs(8);
        check_val("fill8_level", {28'd0, level}, 32'd8);
        check_val("fill8_ovf",   {31'd0, overflow}, 32'd0);
        drive(1'b1, 16'h0108, 1'b1, 16'h0208);
        step();
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_val("fill9_level", {28'd0, level}, 32'd8);
        check_val("fill9_ovf",   {31'd0, overflow}, 32'd1);
`ifdef NN_COLLECTOR_STATS_EN
        check_val("stat_drop", {16'd0, drop_count}, 32'd1);
        check_val("stat_pair", {16'd0, pair_count}, 32'd8);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("drain_w%0d", i), out_data, mk(16'h0200 + 16'(i), 16'h0100 + 16'(i)));
            step();
        end
        out_ready = 1'b0;
        check_val("drain_empty", {31'd0, out_valid}, 32'd0);
        check_val("drain_data0", out_data, 32'h0);

        // Full push/pop collision
        do_flush();
        fill_pairs(8);
        drive(1'b1, 16'h00AA, 1'b0, 16'h0);
        step();
        check_val("coll_half_nopush", {28'd0, level}, 32'd8);
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 1'b1, 16'h00BB);
        step();
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_val("coll_level", {28'd0, level}, 32'd8);
        check_val("coll_ovf",   {31'd0, overflow}, 32'd0);
        check_val("coll_head",  out_data, mk(16'h0201, 16'h0101));
`ifdef NN_COLLECTOR_STATS_EN
        check_val("coll_pairs", {16'd0, pair_count}, 32'd9);
`endif
        out_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check_val($sformatf("coll_w%0d", i), out_data,
                      (i == 8) ? mk(16'h00BB, 16'h00AA) : mk(16'h0200 + 16'(i), 16'h0100 + 16'(i)));
            step();
        end
        out_ready = 1'b0;
        check_val("coll_empty", {31'd0, out_valid}, 32'd0);

        // Reset and flush mid-operation
        mid_op_clear(1'b0);
        mid_op_clear(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nn_output_collector.md
Name: nn_output_collector

Overview:
Sits directly downstream of the 2x2 network top level and consumes its two activation output lanes, nn_data_out_1/2 and nn_valid_out_1/2.
- Column 2 output arrives one cycle after column 1 because of the systolic skew.
- The block re-aligns each column-1/column-2 pair into one 32-bit word.
- Aligned words go into a first-word-fall-through FIFO, drained by a host-side valid/ready port.
- Sticky error flags cover lost or unpaired samples.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2.
DATA_W, 16, width of one column sample; signed Q8.8 as produced upstream.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset.
col_data_1  input  DATA_W  column-1 activation (signed).
col_valid_1  input  1  column-1 sample valid.
col_data_2  input  DATA_W  column-2 activation (signed).
col_valid_2  input  1  column-2 sample valid.
flush  input  1  synchronous clear of FIFO, pairing state and flags.
out_data  output  2*DATA_W  head word: [2*DATA_W-1:DATA_W]=col2, [DATA_W-1:0]=col1.
out_valid  output  1  FIFO not empty.
out_ready  input  1  host accepts head word when out_valid && out_ready.
level  output  $clog2(DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky: a pair was dropped because the FIFO was full.
orphan  output  1  sticky: a column sample arrived without its partner.

Behaviour:
Reset and flush:
- Reset: rst low at a clock edge.
- On reset or flush, all outputs go to 0: out_data=0, out_valid=0, level=0, overflow=0, orphan=0.
- Pairing FSM goes to IDLE and the hold register clears.
- Flush has priority over all same-cycle pushes and pops.

Pairing FSM, states IDLE and HALF, with hold register hold1:
- IDLE, v1 && !v2: hold1<=d1 -> HALF.
- IDLE, v1 && v2: push {d2,d1}; stay IDLE.
- IDLE, !v1 && v2: push {d2,0}; orphan<=1; stay IDLE.
- HALF, v2 && !v1: push {d2,hold1} -> IDLE.
- HALF, v2 && v1: push {d2,hold1}; hold1<=d1; stay HALF.
- HALF, v1 && !v2: push {0,hold1}; orphan<=1; hold1<=d1; stay HALF.
- HALF, neither valid: stay HALF; no timeout.

FIFO:
- First-word-fall-through: out_data shows the head combinationally from registered storage. out_data=0 when empty.
- Push latency: a word pushed at edge N is visible on out_valid/out_data after edge N.
- Pop: when out_valid && out_ready at an edge, the head advances.
- Push when full with no pop: word dropped, overflow<=1, level unchanged.
- Push and pop in the same cycle when full: both succeed, level unchanged.
- Push and pop in the same cycle at level 1: the new word becomes the head.
- Pointers wrap modulo DEPTH. level is exact across the range 0..DEPTH.
- out_ready while empty is ignored.
- Arithmetic: no modification of sample values; bit-exact passthrough.

Optional Feature:
Macro NN_COLLECTOR_STATS_EN.
- When defined:
  - Extra output port drop_count [15:0]: saturating count of pairs dropped on overflow.
  - Extra output port pair_count [15:0]: wrapping count of words successfully pushed.
  - Both clear on reset or flush.
- When undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Decomposition:
Package nn_collector_pkg holds:
- DATA_W default constant.
- Packed struct pair_t {logic signed [DATA_W-1:0] col2; logic signed [DATA_W-1:0] col1;}.
- enum pair_state_t {IDLE, HALF}.

Sub-module collector_fifo:
- Generic FWFT FIFO with ports push, push_data, pop, flush, full, empty, level, head.
- Instantiated once. The pairing FSM, sticky flags and stats counters live in the top.

Test Plan:
- Skewed pair: v1 with d1=16'h0180 at cycle 0, v2 with d2=16'hFF40 at cycle 1 -> one word 32'hFF40_0180, out_valid high from cycle 2, level=1, orphan=0.
- Back-to-back streaming with the 1-cycle skew for 4 pairs (1..4 / 11..14), out_ready=1 -> words {11,1},{12,2},{13,3},{14,4} in order, overflow=0, level never exceeds 2.
- Fill with out_ready=0, DEPTH=8, 9 pairs -> level=8, overflow=1, ninth pair absent. Then out_ready=1 -> first 8 words drained in order. With NN_COLLECTOR_STATS_EN: drop_count=1, pair_count=8.
- Orphan: v1 d1=5 then v1 d1=6 with no v2, then v2 d2=7 -> words {0,5} then {7,6}, orphan=1.
- Full push/pop collision: at level=8 assert out_ready and a completing v2 in the same cycle -> level stays 8, no overflow, new word at the tail.
- Reset and flush mid-operation: with level=3 in HALF, drive rst low for one cycle -> all outputs 0, FSM IDLE. Then v2 alone -> orphan set, word {d2,0}. Repeat the same sequence using flush -> identical result.
